keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 157 +++++++++++++++
 tb/tb_keypad_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Scans a 4x4 active-low keypad, debounces a single key and emits its 4-bit code with a one-clock active-low strobe.
// Latency: 2-clock column synchronizer, then SCAN_CYCLES per row and DEBOUNCE_CYCLES of stable press before the strobe.
// No backpressure: a strobe is one clock wide and is not held; a held key gives one strobe until its release is confirmed.
module keypad_encoder #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] Escolha,
    output logic       enable,
    output logic       key_down
);

    if (SCAN_CYCLES < 3) begin : g_scan_chk
        $error("keypad_encoder: SCAN_CYCLES must be at least 3");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_deb_chk
        $error("keypad_encoder: DEBOUNCE_CYCLES must be at least 1");
    end

    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    col_m, col_s;
    logic [1:0]    r, r_nx;
    logic [1:0]    c, c_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [3:0]    esc_nx;
    logic [3:0]    pat;
    logic          single;
    logic [1:0]    col_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    // A valid press shows exactly one low column on the driven row; anything else is idle or ghosting.
    always_comb begin
        single  = 1'b1;
        col_idx = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: single  = 1'b0;
        endcase
    end

    assign pat = ~(4'b0001 << c);

    always_comb begin
        state_nx = state;
        r_nx     = r;
        c_nx     = c;
        scnt_nx  = scnt;
        dcnt_nx  = dcnt;
        esc_nx   = Escolha;
        case (state)
            SCAN: begin
                if (scnt == SCAN_LAST) begin
                    scnt_nx = '0;
                    if (single) begin
                        c_nx     = col_idx;
                        dcnt_nx  = '0;
                        state_nx = DEBOUNCE;
                    end else begin
                        r_nx = r + 2'd1;
                    end
                end else begin
                    scnt_nx = scnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (col_s == pat) begin
                    if (dcnt == DEB_LAST) begin
                        dcnt_nx  = '0;
                        esc_nx   = {r, c};
                        state_nx = EMIT;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end else begin
                    dcnt_nx  = '0;
                    scnt_nx  = '0;
                    r_nx     = r + 2'd1;
                    state_nx = SCAN;
                end
            end
            EMIT: begin
                dcnt_nx  = '0;
                state_nx = RELEASE;
            end
            RELEASE: begin
                // Row r stays driven, so keys on other rows cannot disturb the release count.
                if (col_s == 4'hF) begin
                    if (dcnt == DEB_LAST) begin
                        dcnt_nx  = '0;
                        scnt_nx  = '0;
                        r_nx     = r + 2'd1;
                        state_nx = SCAN;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end else begin
                    dcnt_nx = '0;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            r        <= 2'd0;
            c        <= 2'd0;
            scnt     <= '0;
            dcnt     <= '0;
            row      <= 4'b1110;
            Escolha  <= 4'b0000;
            enable   <= 1'b1;
            key_down <= 1'b0;
        end else begin
            state    <= state_nx;
            r        <= r_nx;
            c        <= c_nx;
            scnt     <= scnt_nx;
            dcnt     <= dcnt_nx;
            row      <= ~(4'b0001 << r_nx);
            Escolha  <= esc_nx;
            enable   <= (state_nx != EMIT);
            key_down <= (state_nx != SCAN);
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized keypad press/release phases against a key-level model; a monitor pops expected codes on each strobe.
module tb_keypad_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] Escolha;
    logic       enable;
    logic       key_down;

    logic [15:0] keys = 16'h0;
    logic        glitch = 1'b0;

    int total = 0;
    int bad   = 0;
    int onehot_viol = 0;
    int esc_viol    = 0;
    logic [3:0] exp_q[$];

    keypad_encoder #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (col),
        .row      (row),
        .Escolha  (Escolha),
        .enable   (enable),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (keys[4*rr+cc] && !row[rr]) col[cc] = 1'b0;
        if (glitch) col = 4'hF;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected code.
    logic [3:0] last_esc = 4'h0;
    logic       prev_low = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_esc = 4'h0;
            prev_low = 1'b0;
        end else begin
            if (!(row == 4'b1110 || row == 4'b1101 || row == 4'b1011 || row == 4'b0111))
                onehot_viol++;
            if (enable && Escolha != last_esc) esc_viol++;
            last_esc = Escolha;
            if (!enable) begin
                chk("strobe_not_consecutive", int'(prev_low), 0);
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", int'(Escolha), -1);
                end else begin
                    chk("strobe_code", int'(Escolha), int'(exp_q.pop_front()));
                end
            end
            prev_low = !enable;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_kd(input logic v, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (key_down == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press(input int k, input int hold, input int rel);
        keys = 16'h0;
        keys[k] = 1'b1;
        exp_q.push_back(4'((k / 4) * 4 + (k % 4)));
        cycles(hold);
        keys = 16'h0;
        cycles(rel);
    endtask

    logic [3:0] rows[0:20];
    logic       kds[0:20];
    logic       ens[0:20];
    logic [3:0] escs[0:20];

    initial begin
        bit ok;
        int t, k, r, c1, c2, hold;

        // Key row1/col2 held across reset release.
        rst_n = 1'b0;
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_row", int'(row), 4'b1110);
        chk("reset_escolha", int'(Escolha), 0);
        chk("reset_enable", int'(enable), 1);
        chk("reset_key_down", int'(key_down), 0);
        rst_n = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            #1;
            rows[n] = row; kds[n] = key_down; ens[n] = enable; escs[n] = Escolha;
            @(negedge clk);
        end
        chk("c0_row", int'(rows[0]), 4'b1110);
        chk("c3_row", int'(rows[3]), 4'b1110);
        chk("c4_row", int'(rows[4]), 4'b1101);
        chk("c7_row", int'(rows[7]), 4'b1101);
        chk("c7_key_down", int'(kds[7]), 0);
        chk("c8_key_down", int'(kds[8]), 1);
        chk("c15_enable", int'(ens[15]), 1);
        chk("c16_enable", int'(ens[16]), 0);
        chk("c16_escolha", int'(escs[16]), 4'b0110);
        chk("c17_enable", int'(ens[17]), 1);
        keys = 16'h0;
        cycles(40);

        // Corner key and wrap-around of the row pointer.
        keys[15] = 1'b1;
        exp_q.push_back(4'hF);
        cycles(100);
        keys = 16'h0;
        wait_kd(1'b0, 40, ok);
        chk("wrap_release_seen", int'(ok), 1);
        chk("wrap_row", int'(row), 4'b1110);
        cycles(30);

        // One-clock column glitch mid-debounce.
        keys[5] = 1'b1;
        exp_q.push_back(4'd5);
        wait_kd(1'b1, 60, ok);
        chk("glitch_debounce_seen", int'(ok), 1);
        cycles(3);
        glitch = 1'b1;
        cycles(1);
        glitch = 1'b0;
        wait_kd(1'b0, 8, ok);
        chk("glitch_abort_seen", int'(ok), 1);
        chk("glitch_next_row", int'(row), 4'b1011);
        cycles(100);
        keys = 16'h0;
        cycles(40);

        // Two keys on row 0 are ignored; dropping one leaves a valid press.
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        cycles(100);
        exp_q.push_back(4'd0);
        keys[1] = 1'b0;
        cycles(80);
        keys = 16'h0;
        cycles(40);

        // Long hold with an 8-clock release gives two strobes; a 5-clock release gives one.
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd9);
        cycles(200);
        keys = 16'h0;
        cycles(8);
        keys[9] = 1'b1;
        cycles(100);
        keys = 16'h0;
        cycles(40);
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        cycles(200);
        keys = 16'h0;
        cycles(5);
        keys[9] = 1'b1;
        cycles(100);
        keys = 16'h0;
        cycles(40);

        // Code 1010 is emitted like any other.
        press(10, 80, 40);

        // Reset pulse during debounce aborts the press; the held key is found again after rescan.
        keys[13] = 1'b1;
        exp_q.push_back(4'd13);
        wait_kd(1'b1, 60, ok);
        chk("rst_debounce_seen", int'(ok), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_row", int'(row), 4'b1110);
        chk("async_rst_escolha", int'(Escolha), 0);
        chk("async_rst_enable", int'(enable), 1);
        chk("async_rst_key_down", int'(key_down), 0);
        #4 rst_n = 1'b1;
        cycles(100);
        keys = 16'h0;
        cycles(40);

        // Random phases.
        for (int p = 0; p < 16; p++) begin
            t = $urandom_range(0, 3);
            k = $urandom_range(0, 15);
            hold = $urandom_range(60, 150);
            if (t <= 1) begin
                press(k, hold, $urandom_range(20, 50));
            end else if (t == 2) begin
                r  = $urandom_range(0, 3);
                c1 = $urandom_range(0, 3);
                c2 = (c1 + $urandom_range(1, 3)) % 4;
                keys = 16'h0;
                keys[4*r+c1] = 1'b1;
                keys[4*r+c2] = 1'b1;
                cycles(hold);
                keys = 16'h0;
                cycles(30);
            end else begin
                keys = 16'h0;
                keys[k] = 1'b1;
                exp_q.push_back(4'((k / 4) * 4 + (k % 4)));
                cycles(hold);
                keys = 16'h0;
                cycles($urandom_range(1, 5));
                keys[k] = 1'b1;
                cycles(80);
                keys = 16'h0;
                cycles(30);
            end
        end

        cycles(20);
        chk("strobes_outstanding", exp_q.size(), 0);
        chk("row_onehot_violations", onehot_viol, 0);
        chk("escolha_change_violations", esc_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
